pc_ctrl: RTL and testbench
==========================

// Module: pc_ctrl
// PURPOSE
//   Parametrised program-counter unit for the pipelined CPU front end. Holds the fetch PC,
//   steps sequentially, accepts branch/jump redirects, buffers a redirect that arrives
//   during a stall, enters and returns from exceptions with an EPC, and flags misaligned targets.
//   It sits between the next-PC logic/hazard unit and the instruction memory address port.
// PARAMETERS
//   WIDTH      32        PC / address width in bits
//   RESET_VEC  32'h3000  PC value after reset
//   EXC_VEC    32'h4180  exception handler entry address
//   STEP       4         sequential increment in bytes (power of two)
// PORTS
//   clk              in   1      clock, rising edge
//   reset            in   1      synchronous, active-high
//   stall            in   1      hold PC this cycle (hazard unit)
//   redir_valid      in   1      branch/jump taken, one-cycle pulse
//   redir_target     in   WIDTH  redirect destination
//   exc_req          in   1      exception request, one-cycle pulse
//   eret             in   1      return from exception, one-cycle pulse
//   pc               out  WIDTH  current fetch PC (registered)
//   pc_plus          out  WIDTH  pc + STEP (combinational)
//   epc              out  WIDTH  saved exception return address (registered)
//   in_exc           out  1      exception level active (registered)
//   redir_pending    out  1      a redirect is buffered behind a stall
//   misalign         out  1      registered one-cycle pulse: misaligned redirect taken as exception
// BEHAVIOUR
//   Reset (sync, wins over all): pc=RESET_VEC, epc=0, in_exc=0, redir_pending=0, misalign=0,
//     pending target register cleared to 0. Power-up (initial) values equal reset values.
//   Per-edge priority, highest first:
//   1 exc_req: pc<=EXC_VEC; if !in_exc then epc<=pc, in_exc<=1; if in_exc epc unchanged
//     (nested exception does not overwrite EPC). Clears redir_pending. Ignores stall.
//   2 eret: pc<=epc, in_exc<=0, clears redir_pending. Ignores stall. eret with in_exc=0 still
//     loads pc<=epc.
//   3 misaligned redirect (target[log2(STEP)-1:0]!=0), applied when redirect would take effect:
//     treated as exception: pc<=EXC_VEC, epc<=target if !in_exc, in_exc<=1, misalign<=1 for 1 cycle.
//   4 stall=1: pc holds. If redir_valid, latch target, redir_pending<=1 (a later redirect
//     during the same stall overwrites the buffered one).
//   5 stall=0, redir_valid: pc<=redir_target (fresh redirect beats buffered one); pending cleared.
//   6 stall=0, redir_pending: pc<=buffered target; pending<=0.
//   7 otherwise pc<=pc+STEP, modulo 2^WIDTH (wraps to 0, no flag).
//   Latency: redirect/exception/eret visible on pc the cycle after the request edge.
//   Alignment of RESET_VEC/EXC_VEC is the integrator's responsibility; not checked.
//   misalign deasserts the following cycle unless another misaligned redirect is taken.
//   State machine (redirect buffer): IDLE --stall&redir_valid--> PEND;
//     PEND --!stall--> IDLE (apply); PEND --exc_req|eret|reset--> IDLE (drop).
// STRUCTURE
//   Shared cpu_pkg: RESET_VEC/EXC_VEC defaults, STEP, redirect-buffer state enum.
//   One natural sub-module: pc_redir_buf (target register + IDLE/PEND FSM). Rest inline.
// TESTING
//   1 reset 2 cycles, release -> pc 0x3000,0x3004,0x3008; epc=0, in_exc=0.
//   2 redir_valid target 0x3100, stall=0 -> next pc=0x3100, then 0x3104.
//   3 stall=1 + redir 0x3200, stall held 3 cycles -> pc frozen, redir_pending=1; stall drops
//     -> pc=0x3200, pending=0.
//   4 exc_req at pc=0x3010 -> pc=0x4180, epc=0x3010, in_exc=1; second exc_req -> epc stays
//     0x3010; eret -> pc=0x3010, in_exc=0.
//   5 redir target 0x3102 -> pc=0x4180, epc=0x3102, misalign pulse exactly 1 cycle.
//   6 reset asserted while redir_pending=1 and in_exc=1 -> pc=0x3000, pending=0, in_exc=0;
//     pc=0xFFFFFFFC free-running -> wraps to 0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default vectors, fetch step and the
// redirect-buffer state encoding.
package cpu_pkg;

   localparam int          CPU_WIDTH     = 32;
   localparam logic [31:0] CPU_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] CPU_EXC_VEC   = 32'h0000_4180;
   localparam int          CPU_STEP      = 4;

   typedef enum logic {
      RB_IDLE = 1'b0,
      RB_PEND = 1'b1
   } rb_state_t;

endpackage

// File: rtl/pc_redir_buf.sv
// Redirect buffer: holds a branch/jump target that arrived while fetch was
// stalled, until the stall lifts or an exception/eret discards it.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   RB_IDLE | nothing buffered
//   RB_PEND | r_target holds a redirect waiting for !stall
module pc_redir_buf
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_stall,
   input  logic             i_redir_valid,
   input  logic [WIDTH-1:0] i_redir_target,
   input  logic             i_drop,
   output logic             o_pending,
   output logic [WIDTH-1:0] o_target
);

   rb_state_t        r_state = RB_IDLE;
   rb_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_target = '0;
   logic             w_capture;

   assign w_capture = i_stall && i_redir_valid && !i_drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= RB_IDLE;
         r_target <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture)
            r_target <= i_redir_target;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RB_IDLE: if (w_capture) w_state_nxt = RB_PEND;
         RB_PEND: if (i_drop || !i_stall) w_state_nxt = RB_IDLE;
         default: w_state_nxt = RB_IDLE;
      endcase
   end

   always_comb begin
      o_pending = (r_state == RB_PEND);
      o_target  = r_target;
   end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch program counter: sequential stepping, redirects (buffered across
// stalls), exception entry/return with EPC, and misaligned-target trapping.
module pc_ctrl
   import cpu_pkg::*;
#(
   parameter int               WIDTH     = CPU_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(CPU_RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(CPU_EXC_VEC),
   parameter int               STEP      = CPU_STEP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redir_valid,
   input  logic [WIDTH-1:0] redir_target,
   input  logic             exc_req,
   input  logic             eret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic [WIDTH-1:0] epc,
   output logic             in_exc,
   output logic             redir_pending,
   output logic             misalign
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   logic [WIDTH-1:0] r_pc = RESET_VEC;
   logic [WIDTH-1:0] r_epc = '0;
   logic             r_in_exc = 1'b0;
   logic             r_misalign = 1'b0;

   logic             w_pending;
   logic [WIDTH-1:0] w_buf_target;
   logic [WIDTH-1:0] w_target;
   logic             w_apply;
   logic             w_mis;

   pc_redir_buf #(.WIDTH(WIDTH)) u_redir_buf (
      .clk            (clk),
      .reset          (reset),
      .i_stall        (stall),
      .i_redir_valid  (redir_valid),
      .i_redir_target (redir_target),
      .i_drop         (exc_req || eret),
      .o_pending      (w_pending),
      .o_target       (w_buf_target)
   );

   // A fresh redirect beats the buffered one; alignment is judged on whichever wins.
   assign w_target = redir_valid ? redir_target : w_buf_target;
   assign w_apply  = !stall && (redir_valid || w_pending);
   assign w_mis    = w_apply && ((w_target & ALIGN_MASK) != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_VEC;
         r_epc      <= '0;
         r_in_exc   <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= 1'b0;
         if (exc_req) begin
            r_pc <= EXC_VEC;
            if (!r_in_exc) begin
               r_epc    <= r_pc;
               r_in_exc <= 1'b1;
            end
         end else if (eret) begin
            r_pc     <= r_epc;
            r_in_exc <= 1'b0;
         end else if (w_mis) begin
            r_pc       <= EXC_VEC;
            r_misalign <= 1'b1;
            if (!r_in_exc) begin
               r_epc    <= w_target;
               r_in_exc <= 1'b1;
            end
         end else if (stall) begin
            r_pc <= r_pc;
         end else if (w_apply) begin
            r_pc <= w_target;
         end else begin
            r_pc <= pc_plus;
         end
      end
   end

   assign pc            = r_pc;
   assign pc_plus       = r_pc + WIDTH'(STEP);
   assign epc           = r_epc;
   assign in_exc        = r_in_exc;
   assign redir_pending = w_pending;
   assign misalign      = r_misalign;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: stepping, redirects, stalled redirects,
// exceptions/eret, misaligned targets, reset and wrap-around.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall, redir_valid, exc_req, eret;
   logic [31:0] redir_target;
   logic [31:0] pc, pc_plus, epc;
   logic        in_exc, redir_pending, misalign;

   int n_checks = 0;
   int n_fail   = 0;

   pc_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .redir_valid   (redir_valid),
      .redir_target  (redir_target),
      .exc_req       (exc_req),
      .eret          (eret),
      .pc            (pc),
      .pc_plus       (pc_plus),
      .epc           (epc),
      .in_exc        (in_exc),
      .redir_pending (redir_pending),
      .misalign      (misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
      exc_req = 1'b0; eret = 1'b0;

      // 1: reset and sequential stepping
      step(); step();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_epc", epc, 32'h0);
      chk("rst_in_exc", in_exc, 0);
      chk("rst_pending", redir_pending, 0);
      chk("rst_misalign", misalign, 0);
      reset = 1'b0;
      step(); chk("seq_3004", pc, 32'h3004);
      step(); chk("seq_3008", pc, 32'h3008);
      chk("pc_plus", pc_plus, 32'h300C);

      // 2: unstalled redirect
      redir_valid = 1'b1; redir_target = 32'h3100;
      step(); chk("redir_3100", pc, 32'h3100);
      redir_valid = 1'b0;
      step(); chk("redir_next", pc, 32'h3104);

      // 3: redirect buffered behind a 3-cycle stall
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3200;
      step(); chk("stall_hold0", pc, 32'h3104);
      chk("stall_pend0", redir_pending, 1);
      redir_valid = 1'b0;
      step(); step();
      chk("stall_hold2", pc, 32'h3104);
      chk("stall_pend2", redir_pending, 1);
      stall = 1'b0;
      step(); chk("pend_apply", pc, 32'h3200);
      chk("pend_clear", redir_pending, 0);
      step(); chk("pend_next", pc, 32'h3204);

      // 4: exception, nested exception, eret
      redir_valid = 1'b1; redir_target = 32'h3010;
      step(); redir_valid = 1'b0;
      chk("to_3010", pc, 32'h3010);
      exc_req = 1'b1;
      step(); exc_req = 1'b0;
      chk("exc_pc", pc, 32'h4180);
      chk("exc_epc", epc, 32'h3010);
      chk("exc_in", in_exc, 1);
      step(); chk("exc_step", pc, 32'h4184);
      exc_req = 1'b1;
      step(); exc_req = 1'b0;
      chk("nest_pc", pc, 32'h4180);
      chk("nest_epc", epc, 32'h3010);
      eret = 1'b1;
      step(); eret = 1'b0;
      chk("eret_pc", pc, 32'h3010);
      chk("eret_in", in_exc, 0);
      step(); chk("eret_next", pc, 32'h3014);

      // 5: misaligned redirect traps with a single-cycle flag
      redir_valid = 1'b1; redir_target = 32'h3102;
      step(); redir_valid = 1'b0;
      chk("mis_pc", pc, 32'h4180);
      chk("mis_epc", epc, 32'h3102);
      chk("mis_in", in_exc, 1);
      chk("mis_flag", misalign, 1);
      step();
      chk("mis_flag_off", misalign, 0);
      chk("mis_next", pc, 32'h4184);

      // misaligned target buffered during a stall traps when applied; EPC kept while nested
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3301;
      step(); redir_valid = 1'b0; stall = 1'b0;
      chk("mbuf_hold", pc, 32'h4184);
      step();
      chk("mbuf_pc", pc, 32'h4180);
      chk("mbuf_epc", epc, 32'h3102);
      chk("mbuf_flag", misalign, 1);

      // 6: reset while pending and in exception
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3300;
      step(); redir_valid = 1'b0;
      chk("pre_pend", redir_pending, 1);
      chk("pre_in", in_exc, 1);
      reset = 1'b1;
      step(); reset = 1'b0; stall = 1'b0;
      chk("rst2_pc", pc, 32'h3000);
      chk("rst2_pend", redir_pending, 0);
      chk("rst2_in", in_exc, 0);
      chk("rst2_epc", epc, 32'h0);
      step(); chk("rst2_next", pc, 32'h3004);

      // wrap-around
      redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
      step(); redir_valid = 1'b0;
      chk("wrap_top", pc, 32'hFFFF_FFFC);
      chk("wrap_plus", pc_plus, 32'h0);
      step(); chk("wrap_zero", pc, 32'h0);
      step(); chk("wrap_four", pc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
